mem_access_ctrl: RTL and testbench

- Initiator side of the synchronous word RAM port (addr/cs/rd/oe/write_data/read_data).
- Takes byte, halfword and word load/store requests from the CPU load/store stage and turns them into RAM word accesses.
- Sub-word stores use read-modify-write, because the RAM has no byte enables.
- Loads return sign- or zero-extended data with a single-cycle response pulse.

---
 rtl/mem_access_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 469 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Load/store initiator for a single-port word RAM without byte enables.
// Sub-word stores are done as read-modify-write; loads are lane-extended.
module mem_access_ctrl #(
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic [ADDR_W-3:0] mem_addr,
   output logic              mem_cs,
   output logic              mem_rd,
   output logic              mem_oe,
   output logic [31:0]       mem_write_data,
   input  logic [31:0]       mem_read_data
);

   typedef enum logic [2:0] {
      IDLE,
      READ,
      CAPTURE,
      WRITE,
      FAULT
   } state_t;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   state_t state;
   state_t state_nx;

   logic              lat_we;
   logic [1:0]        lat_size;
   logic              lat_uns;
   logic [1:0]        lat_off;
   logic [31:0]       lat_wdata;

   logic              cs_nx;
   logic              rd_nx;
   logic              oe_nx;
   logic [ADDR_W-3:0] addr_nx;
   logic [31:0]       wdata_nx;
   logic              rv_nx;
   logic [31:0]       rdata_nx;
   logic              err_nx;
   logic              req_bad;
   logic              accept;

   assign req_ready = (state == IDLE);
   assign accept    = req_valid & req_ready;

   always_comb begin
      unique case (req_size)
         SZ_BYTE: req_bad = 1'b0;
         SZ_HALF: req_bad = req_addr[0];
         SZ_WORD: req_bad = |req_addr[1:0];
         default: req_bad = 1'b1;
      endcase
   end

   // Replace the addressed lane of the word just read with store data.
   function automatic logic [31:0] merge(
      input logic [31:0] word,
      input logic [31:0] data,
      input logic [1:0]  size,
      input logic [1:0]  off
   );
      logic [31:0] r;
      r = word;
      unique case (size)
         SZ_BYTE: r[{off, 3'b000} +: 8] = data[7:0];
         SZ_HALF: r[{off[1], 4'b0000} +: 16] = data[15:0];
         default: r = data;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] extend(
      input logic [31:0] word,
      input logic [1:0]  size,
      input logic        uns,
      input logic [1:0]  off
   );
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = word[{off, 3'b000} +: 8];
      h = word[{off[1], 4'b0000} +: 16];
      unique case (size)
         SZ_BYTE: r = uns ? {24'd0, b} : {{24{b[7]}}, b};
         SZ_HALF: r = uns ? {16'd0, h} : {{16{h[15]}}, h};
         default: r = word;
      endcase
      return r;
   endfunction

   always_comb begin
      state_nx = state;
      cs_nx    = 1'b0;
      rd_nx    = 1'b1;
      oe_nx    = 1'b0;
      addr_nx  = mem_addr;
      wdata_nx = mem_write_data;
      rv_nx    = 1'b0;
      rdata_nx = resp_rdata;
      err_nx   = resp_err;
      unique case (state)
         IDLE: begin
            if (req_valid) begin
               if (req_bad) begin
                  state_nx = FAULT;
               end else if (req_we && req_size == SZ_WORD) begin
                  state_nx = WRITE;
                  cs_nx    = 1'b1;
                  rd_nx    = 1'b0;
                  addr_nx  = req_addr[ADDR_W-1:2];
                  wdata_nx = req_wdata;
               end else begin
                  state_nx = READ;
                  cs_nx    = 1'b1;
                  oe_nx    = 1'b1;
                  addr_nx  = req_addr[ADDR_W-1:2];
               end
            end
         end
         READ: begin
            // Keep oe up so the RAM drives data during the capture cycle.
            state_nx = CAPTURE;
            oe_nx    = 1'b1;
         end
         CAPTURE: begin
            if (lat_we) begin
               state_nx = WRITE;
               cs_nx    = 1'b1;
               rd_nx    = 1'b0;
               wdata_nx = merge(mem_read_data, lat_wdata,
                                lat_size, lat_off);
            end else begin
               state_nx = IDLE;
               rv_nx    = 1'b1;
               err_nx   = 1'b0;
               rdata_nx = extend(mem_read_data, lat_size,
                                 lat_uns, lat_off);
            end
         end
         WRITE: begin
            state_nx = IDLE;
            rv_nx    = 1'b1;
            err_nx   = 1'b0;
            rdata_nx = 32'd0;
         end
         FAULT: begin
            state_nx = IDLE;
            rv_nx    = 1'b1;
            err_nx   = 1'b1;
            rdata_nx = 32'd0;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         mem_cs         <= 1'b0;
         mem_rd         <= 1'b1;
         mem_oe         <= 1'b0;
         mem_addr       <= '0;
         mem_write_data <= 32'd0;
         resp_valid     <= 1'b0;
         resp_rdata     <= 32'd0;
         resp_err       <= 1'b0;
      end else begin
         state          <= state_nx;
         mem_cs         <= cs_nx;
         mem_rd         <= rd_nx;
         mem_oe         <= oe_nx;
         mem_addr       <= addr_nx;
         mem_write_data <= wdata_nx;
         resp_valid     <= rv_nx;
         resp_rdata     <= rdata_nx;
         resp_err       <= err_nx;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_we    <= 1'b0;
         lat_size  <= 2'b00;
         lat_uns   <= 1'b0;
         lat_off   <= 2'b00;
         lat_wdata <= 32'd0;
      end else if (accept) begin
         lat_we    <= req_we;
         lat_size  <= req_size;
         lat_uns   <= req_unsigned;
         lat_off   <= req_addr[1:0];
         lat_wdata <= req_wdata;
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: behavioural RAM plus a word-array reference
// model; directed plan scenarios followed by randomized requests.
module tb_mem_access_ctrl;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [11:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [9:0]  mem_addr;
   logic        mem_cs;
   logic        mem_rd;
   logic        mem_oe;
   logic [31:0] mem_write_data;
   logic [31:0] mem_read_data;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] ram [1024];
   logic [31:0] ref_mem [1024];

   mem_access_ctrl #(.ADDR_W(12)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_we         (req_we),
      .req_size       (req_size),
      .req_unsigned   (req_unsigned),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .resp_valid     (resp_valid),
      .resp_rdata     (resp_rdata),
      .resp_err       (resp_err),
      .mem_addr       (mem_addr),
      .mem_cs         (mem_cs),
      .mem_rd         (mem_rd),
      .mem_oe         (mem_oe),
      .mem_write_data (mem_write_data),
      .mem_read_data  (mem_read_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous RAM: write on cs&!rd, registered read on cs&rd&oe.
   always @(posedge clk) begin
      if (mem_cs && !mem_rd) ram[mem_addr] <= mem_write_data;
      if (mem_cs && mem_rd && mem_oe) mem_read_data <= ram[mem_addr];
   end

   // Reference: what the request should do to a plain array of words.
   function automatic void model(
      input  logic        we,
      input  logic [1:0]  sz,
      input  logic        uns,
      input  logic [11:0] a,
      input  logic [31:0] wd,
      output logic        err,
      output logic [31:0] rd,
      output int          lat,
      output int          sel
   );
      int          nbits;
      int          sh;
      int          w;
      logic [63:0] m;
      logic [31:0] v;
      err = (sz == 2'd3) || (sz == 2'd1 && a[0]) ||
            (sz == 2'd2 && a[1:0] != 2'd0);
      rd  = 32'd0;
      if (err) begin
         lat = 1;
         sel = 0;
         return;
      end
      nbits = 8 << sz;
      sh    = 8 * int'(a[1:0]);
      w     = int'(a[11:2]);
      m     = (64'd1 << nbits) - 64'd1;
      if (!we) begin
         v = (ref_mem[w] >> sh) & m[31:0];
         if (!uns && nbits < 32 && v[nbits-1]) v = v | ~m[31:0];
         rd  = v;
         lat = 2;
         sel = 1;
      end else begin
         ref_mem[w] = (ref_mem[w] & ~(m[31:0] << sh)) |
                      ((wd & m[31:0]) << sh);
         lat = (nbits == 32) ? 1 : 3;
         sel = (nbits == 32) ? 1 : 2;
      end
   endfunction

   task automatic issue(
      input  logic        we,
      input  logic [1:0]  sz,
      input  logic        uns,
      input  logic [11:0] a,
      input  logic [31:0] wd,
      output int          lat,
      output logic [31:0] rd,
      output logic        er,
      output int          ncs,
      output logic [9:0]  waddr,
      output logic [31:0] wdat
   );
      lat   = -1;
      rd    = 32'hx;
      er    = 1'bx;
      ncs   = 0;
      waddr = 10'h3ff;
      wdat  = 32'hx;
      @(negedge clk);
      req_valid    = 1'b1;
      req_we       = we;
      req_size     = sz;
      req_unsigned = uns;
      req_addr     = a;
      req_wdata    = wd;
      @(posedge clk);
      #1;
      req_valid    = 1'b0;
      req_we       = 1'($urandom);
      req_size     = 2'($urandom);
      req_addr     = 12'($urandom);
      req_wdata    = $urandom;
      for (int k = 1; k <= 8; k++) begin
         if (mem_cs) begin
            ncs++;
            if (!mem_rd) begin
               waddr = mem_addr;
               wdat  = mem_write_data;
            end
         end
         @(posedge clk);
         #1;
         if (resp_valid) begin
            lat = k;
            rd  = resp_rdata;
            er  = resp_err;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      vectors++;
      if ({req_ready, mem_cs, mem_rd, mem_oe} !== 4'b1010) begin
         miscompares++;
         $display("FAIL reset_ctl: got %b want 1010",
                  {req_ready, mem_cs, mem_rd, mem_oe});
      end
      vectors++;
      if ({mem_addr, mem_write_data, resp_rdata} !== 74'd0 ||
          resp_valid !== 1'b0 || resp_err !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_data: got %h %h %h %b %b", mem_addr,
                  mem_write_data, resp_rdata, resp_valid, resp_err);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      vectors++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_release: ready %b valid %b want 1 0",
                  req_ready, resp_valid);
      end
   endtask

   task automatic test_word;
      int lat, ncs, mlat, msel;
      logic [31:0] rd, wdat, mrd;
      logic er, merr;
      logic [9:0] wa;
      model(1'b1, 2'd2, 1'b0, 12'h010, 32'hDEADBEEF,
            merr, mrd, mlat, msel);
      issue(1'b1, 2'd2, 1'b0, 12'h010, 32'hDEADBEEF,
            lat, rd, er, ncs, wa, wdat);
      vectors++;
      if (lat !== 1 || ncs !== 1 || wa !== 10'd4 ||
          wdat !== 32'hDEADBEEF) begin
         miscompares++;
         $display("FAIL word_store: lat %0d cs %0d addr %0d data %h want 1 1 4 deadbeef",
                  lat, ncs, wa, wdat);
      end
      vectors++;
      if (rd !== 32'd0 || er !== 1'b0 || ram[4] !== 32'hDEADBEEF) begin
         miscompares++;
         $display("FAIL word_store_resp: rdata %h err %b ram %h",
                  rd, er, ram[4]);
      end
      model(1'b0, 2'd2, 1'b0, 12'h010, 32'd0, merr, mrd, mlat, msel);
      issue(1'b0, 2'd2, 1'b0, 12'h010, 32'd0,
            lat, rd, er, ncs, wa, wdat);
      vectors++;
      if (lat !== 2 || rd !== 32'hDEADBEEF || er !== 1'b0) begin
         miscompares++;
         $display("FAIL word_load: lat %0d rdata %h err %b want 2 deadbeef 0",
                  lat, rd, er);
      end
   endtask

   task automatic test_rmw;
      int lat, ncs, mlat, msel;
      logic [31:0] rd, wdat, mrd;
      logic er, merr;
      logic [9:0] wa;
      model(1'b1, 2'd2, 1'b0, 12'h010, 32'h11223344,
            merr, mrd, mlat, msel);
      issue(1'b1, 2'd2, 1'b0, 12'h010, 32'h11223344,
            lat, rd, er, ncs, wa, wdat);
      model(1'b1, 2'd0, 1'b0, 12'h012, 32'h000000AB,
            merr, mrd, mlat, msel);
      issue(1'b1, 2'd0, 1'b0, 12'h012, 32'hFFFFFFAB,
            lat, rd, er, ncs, wa, wdat);
      vectors++;
      if (lat !== 3 || ncs !== 2 || wa !== 10'd4 ||
          wdat !== 32'h11AB3344) begin
         miscompares++;
         $display("FAIL byte_rmw: lat %0d cs %0d addr %0d data %h want 3 2 4 11ab3344",
                  lat, ncs, wa, wdat);
      end
      vectors++;
      if (ram[4] !== 32'h11AB3344 || er !== 1'b0 || rd !== 32'd0) begin
         miscompares++;
         $display("FAIL byte_rmw_ram: ram %h err %b rdata %h want 11ab3344 0 0",
                  ram[4], er, rd);
      end
   endtask

   task automatic test_extend;
      int lat, ncs;
      logic [31:0] rd, wdat;
      logic er;
      logic [9:0] wa;
      logic [31:0] want [3];
      logic [1:0]  sz [3];
      logic        un [3];
      logic [11:0] ad [3];
      want = '{32'hFFFFFFAB, 32'h000000AB, 32'h00003344};
      sz   = '{2'd0, 2'd0, 2'd1};
      un   = '{1'b0, 1'b1, 1'b0};
      ad   = '{12'h012, 12'h012, 12'h010};
      for (int i = 0; i < 3; i++) begin
         issue(1'b0, sz[i], un[i], ad[i], 32'd0,
               lat, rd, er, ncs, wa, wdat);
         vectors++;
         if (rd !== want[i] || lat !== 2 || er !== 1'b0) begin
            miscompares++;
            $display("FAIL extend_%0d: rdata %h lat %0d err %b want %h 2 0",
                     i, rd, lat, er, want[i]);
         end
      end
   endtask

   task automatic test_errors;
      int lat, ncs;
      logic [31:0] rd, wdat;
      logic er;
      logic [9:0] wa;
      logic        we [3];
      logic [1:0]  sz [3];
      logic [11:0] ad [3];
      we = '{1'b0, 1'b1, 1'b0};
      sz = '{2'd2, 2'd1, 2'd3};
      ad = '{12'h011, 12'h013, 12'h010};
      for (int i = 0; i < 3; i++) begin
         issue(we[i], sz[i], 1'b0, ad[i], 32'h12345678,
               lat, rd, er, ncs, wa, wdat);
         vectors++;
         if (er !== 1'b1 || rd !== 32'd0 || ncs !== 0 || lat !== 1) begin
            miscompares++;
            $display("FAIL error_%0d: err %b rdata %h cs %0d lat %0d want 1 0 0 1",
                     i, er, rd, ncs, lat);
         end
      end
      vectors++;
      if (ram[4] !== ref_mem[4]) begin
         miscompares++;
         $display("FAIL error_ram: ram %h want %h", ram[4], ref_mem[4]);
      end
   endtask

   task automatic test_back_to_back;
      int mlat, msel, lat;
      logic [31:0] mrd, exp_ld;
      logic merr;
      model(1'b0, 2'd2, 1'b0, 12'h010, 32'd0, merr, exp_ld, mlat, msel);
      model(1'b1, 2'd2, 1'b0, 12'h020, 32'hCAFEF00D,
            merr, mrd, mlat, msel);
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_size  = 2'd2;
      req_addr  = 12'h010;
      @(posedge clk);
      #1;
      req_we    = 1'b1;
      req_addr  = 12'h020;
      req_wdata = 32'hCAFEF00D;
      lat = -1;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk);
         #1;
         if (resp_valid) begin
            lat = k;
            break;
         end
      end
      vectors++;
      if (lat !== 2 || resp_rdata !== exp_ld || req_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_load: lat %0d rdata %h ready %b want 2 %h 1",
                  lat, resp_rdata, req_ready, exp_ld);
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      vectors++;
      if (!(mem_cs === 1'b1 && mem_rd === 1'b0 && mem_addr === 10'd8)) begin
         miscompares++;
         $display("FAIL b2b_write: cs %b rd %b addr %0d want 1 0 8",
                  mem_cs, mem_rd, mem_addr);
      end
      @(posedge clk);
      #1;
      vectors++;
      if (resp_valid !== 1'b1 || ram[8] !== 32'hCAFEF00D ||
          ram[4] !== ref_mem[4]) begin
         miscompares++;
         $display("FAIL b2b_store: valid %b ram8 %h ram4 %h want 1 cafef00d %h",
                  resp_valid, ram[8], ram[4], ref_mem[4]);
      end
   endtask

   task automatic test_random;
      int lat, ncs, mlat, msel, bad;
      logic [31:0] rd, wdat, mrd, wd;
      logic er, merr, we, un;
      logic [1:0] sz;
      logic [11:0] a;
      logic [9:0] wa;
      for (int w = 0; w < 16; w++) begin
         wd = $urandom;
         model(1'b1, 2'd2, 1'b0, 12'(w * 4), wd, merr, mrd, mlat, msel);
         issue(1'b1, 2'd2, 1'b0, 12'(w * 4), wd,
               lat, rd, er, ncs, wa, wdat);
      end
      for (int i = 0; i < 200; i++) begin
         we = 1'($urandom);
         sz = 2'($urandom);
         un = 1'($urandom);
         a  = 12'($urandom_range(0, 63));
         wd = $urandom;
         model(we, sz, un, a, wd, merr, mrd, mlat, msel);
         issue(we, sz, un, a, wd, lat, rd, er, ncs, wa, wdat);
         vectors++;
         if (lat !== mlat || rd !== mrd || er !== merr ||
             ncs !== msel) begin
            miscompares++;
            $display("FAIL random_%0d: we %b sz %0d a %h lat %0d/%0d rdata %h/%h err %b/%b cs %0d/%0d",
                     i, we, sz, a, lat, mlat, rd, mrd, er, merr,
                     ncs, msel);
         end
      end
      bad = 0;
      for (int w = 0; w < 16; w++)
         if (ram[w] !== ref_mem[w]) bad++;
      vectors++;
      if (bad !== 0) begin
         miscompares++;
         $display("FAIL random_ram: %0d words differ, want 0", bad);
      end
   endtask

   task automatic test_mid_reset;
      int lat, ncs, mlat, msel, pulses;
      logic [31:0] rd, wdat, mrd, keep;
      logic er, merr;
      logic [9:0] wa;
      keep = ref_mem[4];
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_size  = 2'd0;
      req_addr  = 12'h012;
      req_wdata = {24'd0, ~keep[23:16]};
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      vectors++;
      if (mem_cs !== 1'b0 || mem_oe !== 1'b1 || req_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_capture: cs %b oe %b ready %b want 0 1 0",
                  mem_cs, mem_oe, req_ready);
      end
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({req_ready, mem_cs, mem_rd, mem_oe, resp_valid, resp_err}
          !== 6'b101000 ||
          {mem_addr, mem_write_data, resp_rdata} !== 74'd0) begin
         miscompares++;
         $display("FAIL mid_reset: ctl %b addr %h wd %h rdata %h",
                  {req_ready, mem_cs, mem_rd, mem_oe, resp_valid,
                   resp_err}, mem_addr, mem_write_data, resp_rdata);
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1;
         if (resp_valid || mem_cs || !req_ready) pulses++;
      end
      vectors++;
      if (pulses !== 0 || ram[4] !== keep) begin
         miscompares++;
         $display("FAIL mid_after: activity %0d ram %h want 0 %h",
                  pulses, ram[4], keep);
      end
      model(1'b0, 2'd2, 1'b0, 12'h010, 32'd0, merr, mrd, mlat, msel);
      issue(1'b0, 2'd2, 1'b0, 12'h010, 32'd0,
            lat, rd, er, ncs, wa, wdat);
      vectors++;
      if (rd !== mrd || lat !== 2) begin
         miscompares++;
         $display("FAIL mid_reload: rdata %h lat %0d want %h 2",
                  rd, lat, mrd);
      end
   endtask

   initial begin
      req_valid    = 1'b0;
      req_we       = 1'b0;
      req_size     = 2'd0;
      req_unsigned = 1'b0;
      req_addr     = 12'd0;
      req_wdata    = 32'd0;
      test_reset();
      test_word();
      test_rmw();
      test_extend();
      test_errors();
      test_back_to_back();
      test_random();
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
